// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: CDB wakeup, dispatch-time capture, one issue per cycle.
// Optional RS_AGE_ORDER_EN selects oldest-ready issue; default build issues lowest-index ready entry.
module alu_rs #(
   parameter int RS_SIZE      = 8,
   parameter int RS_IDX_WIDTH = 3,
   parameter int ROB_ID_WIDTH = 4,
   parameter int ALU_OP_WIDTH = 4,
   parameter int XLEN         = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    dec_valid,
   input  logic [ALU_OP_WIDTH-1:0] dec_op,
   input  logic [ROB_ID_WIDTH-1:0] dec_rob_id,
   input  logic [XLEN-1:0]         dec_val_1,
   input  logic [XLEN-1:0]         dec_val_2,
   input  logic                    dec_dep_1,
   input  logic                    dec_dep_2,
   input  logic [ROB_ID_WIDTH-1:0] dec_tag_1,
   input  logic [ROB_ID_WIDTH-1:0] dec_tag_2,
   input  logic                    cdb_alu_ready,
   input  logic [ROB_ID_WIDTH-1:0] cdb_alu_rob_id,
   input  logic [XLEN-1:0]         cdb_alu_value,
   input  logic                    cdb_lsb_ready,
   input  logic [ROB_ID_WIDTH-1:0] cdb_lsb_rob_id,
   input  logic [XLEN-1:0]         cdb_lsb_value,
   output logic                    full,
   output logic                    rs_ready,
   output logic [ALU_OP_WIDTH-1:0] rs_op,
   output logic [XLEN-1:0]         rs_val_1,
   output logic [XLEN-1:0]         rs_val_2,
   output logic [ROB_ID_WIDTH-1:0] alu_rob_id
);
   logic [RS_SIZE-1:0]      r_busy;
   logic [RS_SIZE-1:0]      r_dep_1;
   logic [RS_SIZE-1:0]      r_dep_2;
   logic [ALU_OP_WIDTH-1:0] r_op    [RS_SIZE];
   logic [ROB_ID_WIDTH-1:0] r_rob   [RS_SIZE];
   logic [XLEN-1:0]         r_val_1 [RS_SIZE];
   logic [XLEN-1:0]         r_val_2 [RS_SIZE];
   logic [ROB_ID_WIDTH-1:0] r_tag_1 [RS_SIZE];
   logic [ROB_ID_WIDTH-1:0] r_tag_2 [RS_SIZE];
   logic [ROB_ID_WIDTH-1:0] r_rs_rob;
`ifdef RS_AGE_ORDER_EN
   // r_age[i][j] set: entry j was dispatched before entry i
   logic [RS_SIZE-1:0]      r_age   [RS_SIZE];
`endif

   logic [RS_SIZE-1:0]      w_rdy;
   logic [RS_IDX_WIDTH-1:0] w_free_idx;
   logic [RS_IDX_WIDTH-1:0] w_sel_idx;
   logic                    w_sel_found;
   logic                    w_dispatch;
   logic                    w_dec_alu_1;
   logic                    w_dec_lsb_1;
   logic                    w_dec_alu_2;
   logic                    w_dec_lsb_2;

   assign full        = &r_busy;
   assign w_rdy       = r_busy & ~r_dep_1 & ~r_dep_2;
   assign w_dispatch  = dec_valid && !full;
   assign w_dec_alu_1 = dec_dep_1 && cdb_alu_ready && (cdb_alu_rob_id == dec_tag_1);
   assign w_dec_lsb_1 = dec_dep_1 && cdb_lsb_ready && (cdb_lsb_rob_id == dec_tag_1);
   assign w_dec_alu_2 = dec_dep_2 && cdb_alu_ready && (cdb_alu_rob_id == dec_tag_2);
   assign w_dec_lsb_2 = dec_dep_2 && cdb_lsb_ready && (cdb_lsb_rob_id == dec_tag_2);

   always_comb begin
      w_free_idx  = '0;
      w_sel_idx   = '0;
      w_sel_found = 1'b0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!r_busy[i]) w_free_idx = RS_IDX_WIDTH'(i);
      end
`ifdef RS_AGE_ORDER_EN
      for (int i = 0; i < RS_SIZE; i++) begin
         if (w_rdy[i] && ((r_age[i] & w_rdy) == '0)) begin
            w_sel_idx   = RS_IDX_WIDTH'(i);
            w_sel_found = 1'b1;
         end
      end
`else
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (w_rdy[i]) begin
            w_sel_idx   = RS_IDX_WIDTH'(i);
            w_sel_found = 1'b1;
         end
      end
`endif
   end

   // Payload needs no reset: every consumer is qualified by r_busy
   always_ff @(posedge clk) begin
      for (int i = 0; i < RS_SIZE; i++) begin
         if (r_busy[i] && r_dep_1[i]) begin
            if (cdb_alu_ready && (r_tag_1[i] == cdb_alu_rob_id)) begin
               r_val_1[i] <= cdb_alu_value;
               r_dep_1[i] <= 1'b0;
            end else if (cdb_lsb_ready && (r_tag_1[i] == cdb_lsb_rob_id)) begin
               r_val_1[i] <= cdb_lsb_value;
               r_dep_1[i] <= 1'b0;
            end
         end
         if (r_busy[i] && r_dep_2[i]) begin
            if (cdb_alu_ready && (r_tag_2[i] == cdb_alu_rob_id)) begin
               r_val_2[i] <= cdb_alu_value;
               r_dep_2[i] <= 1'b0;
            end else if (cdb_lsb_ready && (r_tag_2[i] == cdb_lsb_rob_id)) begin
               r_val_2[i] <= cdb_lsb_value;
               r_dep_2[i] <= 1'b0;
            end
         end
      end
      if (w_dispatch) begin
         r_op[w_free_idx]    <= dec_op;
         r_rob[w_free_idx]   <= dec_rob_id;
         r_tag_1[w_free_idx] <= dec_tag_1;
         r_tag_2[w_free_idx] <= dec_tag_2;
         r_dep_1[w_free_idx] <= dec_dep_1 && !w_dec_alu_1 && !w_dec_lsb_1;
         r_dep_2[w_free_idx] <= dec_dep_2 && !w_dec_alu_2 && !w_dec_lsb_2;
         r_val_1[w_free_idx] <= w_dec_alu_1 ? cdb_alu_value :
                                w_dec_lsb_1 ? cdb_lsb_value : dec_val_1;
         r_val_2[w_free_idx] <= w_dec_alu_2 ? cdb_alu_value :
                                w_dec_lsb_2 ? cdb_lsb_value : dec_val_2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy     <= '0;
         rs_ready   <= 1'b0;
         rs_op      <= '0;
         rs_val_1   <= '0;
         rs_val_2   <= '0;
         r_rs_rob   <= '0;
         alu_rob_id <= '0;
`ifdef RS_AGE_ORDER_EN
         for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
`endif
      end else if (flush) begin
         r_busy     <= '0;
         rs_ready   <= 1'b0;
         rs_op      <= '0;
         rs_val_1   <= '0;
         rs_val_2   <= '0;
         r_rs_rob   <= '0;
         alu_rob_id <= '0;
`ifdef RS_AGE_ORDER_EN
         for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
`endif
      end else begin
         if (rs_ready) alu_rob_id <= r_rs_rob;
         rs_ready <= w_sel_found;
         if (w_sel_found) begin
            rs_op             <= r_op[w_sel_idx];
            rs_val_1          <= r_val_1[w_sel_idx];
            rs_val_2          <= r_val_2[w_sel_idx];
            r_rs_rob          <= r_rob[w_sel_idx];
            r_busy[w_sel_idx] <= 1'b0;
         end else begin
            rs_op    <= '0;
            rs_val_1 <= '0;
            rs_val_2 <= '0;
         end
         // Free slot is taken from pre-edge busy, so it never collides with the issuing slot
         if (w_dispatch) begin
            r_busy[w_free_idx] <= 1'b1;
`ifdef RS_AGE_ORDER_EN
            for (int j = 0; j < RS_SIZE; j++) r_age[j][w_free_idx] <= 1'b0;
            r_age[w_free_idx] <= r_busy;
`endif
         end
      end
   end
endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - Directed and randomized self-checking bench for alu_rs with a slot/sequence reference model.
module tb_alu_rs;
   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush, dec_valid, dec_dep_1, dec_dep_2;
   logic [3:0]  dec_op, dec_rob_id, dec_tag_1, dec_tag_2;
   logic [31:0] dec_val_1, dec_val_2;
   logic        cdb_alu_ready, cdb_lsb_ready;
   logic [3:0]  cdb_alu_rob_id, cdb_lsb_rob_id;
   logic [31:0] cdb_alu_value, cdb_lsb_value;
   logic        full, rs_ready;
   logic [3:0]  rs_op, alu_rob_id;
   logic [31:0] rs_val_1, rs_val_2;

   always #5 clk = ~clk;

   alu_rs dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dec_valid(dec_valid), .dec_op(dec_op), .dec_rob_id(dec_rob_id),
      .dec_val_1(dec_val_1), .dec_val_2(dec_val_2),
      .dec_dep_1(dec_dep_1), .dec_dep_2(dec_dep_2),
      .dec_tag_1(dec_tag_1), .dec_tag_2(dec_tag_2),
      .cdb_alu_ready(cdb_alu_ready), .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_value(cdb_alu_value),
      .cdb_lsb_ready(cdb_lsb_ready), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
      .full(full), .rs_ready(rs_ready), .rs_op(rs_op),
      .rs_val_1(rs_val_1), .rs_val_2(rs_val_2), .alu_rob_id(alu_rob_id)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int seq_ctr  = 0;

   // Reference model: slots with a dispatch sequence number
   logic        m_busy [N];
   logic [3:0]  m_op   [N];
   logic [3:0]  m_rob  [N];
   logic [31:0] m_v1   [N];
   logic [31:0] m_v2   [N];
   logic        m_d1   [N];
   logic        m_d2   [N];
   logic [3:0]  m_t1   [N];
   logic [3:0]  m_t2   [N];
   int          m_seq  [N];
   logic        m_rdy;
   logic [3:0]  m_rop, m_rrob, m_arob;
   logic [31:0] m_rv1, m_rv2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic hit(input logic v, input logic [3:0] a, input logic [3:0] b);
      return v && (a == b);
   endfunction

   function automatic logic all_busy();
      logic r = 1'b1;
      for (int i = 0; i < N; i++) r = r & m_busy[i];
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_rdy = 1'b0; m_rop = '0; m_rv1 = '0; m_rv2 = '0; m_arob = '0; m_rrob = '0;
   endtask

   task automatic wake(input logic [3:0] tag, inout logic dep, inout logic [31:0] val);
      if (dep) begin
         if (hit(cdb_alu_ready, cdb_alu_rob_id, tag)) begin dep = 1'b0; val = cdb_alu_value; end
         else if (hit(cdb_lsb_ready, cdb_lsb_rob_id, tag)) begin dep = 1'b0; val = cdb_lsb_value; end
      end
   endtask

   task automatic model_step();
      int sel = -1;
      int fr  = -1;
      if (rst || flush) begin
         model_clear();
      end else begin
         for (int i = 0; i < N; i++) begin
            if (m_busy[i] && !m_d1[i] && !m_d2[i]) begin
`ifdef RS_AGE_ORDER_EN
               if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
               if (sel < 0) sel = i;
`endif
            end
            if (!m_busy[i] && fr < 0) fr = i;
         end
         if (m_rdy) m_arob = m_rrob;
         for (int i = 0; i < N; i++) begin
            if (m_busy[i]) begin
               wake(m_t1[i], m_d1[i], m_v1[i]);
               wake(m_t2[i], m_d2[i], m_v2[i]);
            end
         end
         m_rdy = (sel >= 0);
         if (sel >= 0) begin
            m_rop = m_op[sel]; m_rv1 = m_v1[sel]; m_rv2 = m_v2[sel]; m_rrob = m_rob[sel];
            m_busy[sel] = 1'b0;
         end else begin
            m_rop = '0; m_rv1 = '0; m_rv2 = '0;
         end
         if (dec_valid && fr >= 0) begin
            m_busy[fr] = 1'b1; m_op[fr] = dec_op; m_rob[fr] = dec_rob_id;
            m_seq[fr] = seq_ctr; seq_ctr++;
            m_t1[fr] = dec_tag_1; m_t2[fr] = dec_tag_2;
            m_d1[fr] = dec_dep_1; m_v1[fr] = dec_val_1;
            m_d2[fr] = dec_dep_2; m_v2[fr] = dec_val_2;
            wake(dec_tag_1, m_d1[fr], m_v1[fr]);
            wake(dec_tag_2, m_d2[fr], m_v2[fr]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      chk("full", full, all_busy());
      chk("rs_ready", rs_ready, m_rdy);
      chk("rs_op", rs_op, m_rop);
      chk("rs_val_1", rs_val_1, m_rv1);
      chk("rs_val_2", rs_val_2, m_rv2);
      chk("alu_rob_id", alu_rob_id, m_arob);
   endtask

   task automatic clear_in();
      flush = 0; dec_valid = 0; dec_op = 0; dec_rob_id = 0; dec_val_1 = 0; dec_val_2 = 0;
      dec_dep_1 = 0; dec_dep_2 = 0; dec_tag_1 = 0; dec_tag_2 = 0;
      cdb_alu_ready = 0; cdb_alu_rob_id = 0; cdb_alu_value = 0;
      cdb_lsb_ready = 0; cdb_lsb_rob_id = 0; cdb_lsb_value = 0;
   endtask

   task automatic set_dec(input logic [3:0] op, input logic [3:0] rob, input logic [31:0] v1,
                          input logic [31:0] v2, input logic d1, input logic [3:0] t1);
      dec_valid = 1; dec_op = op; dec_rob_id = rob; dec_val_1 = v1; dec_val_2 = v2;
      dec_dep_1 = d1; dec_tag_1 = t1; dec_dep_2 = 0; dec_tag_2 = 0;
   endtask

   initial begin
      logic [3:0] first_op, second_op;
      clear_in();
      model_clear();
      tick(); tick();
      chk("reset_rs_ready", rs_ready, 1'b0);
      chk("reset_full", full, 1'b0);
      chk("reset_alu_rob_id", alu_rob_id, 4'd0);
      rst = 0;

      // ADD 3,4 rob 2
      set_dec(4'd1, 4'd2, 32'd3, 32'd4, 1'b0, 4'd0);
      tick(); clear_in();
      tick();
      chk("add_rs_ready", rs_ready, 1'b1);
      chk("add_rs_op", rs_op, 4'd1);
      chk("add_val_1", rs_val_1, 32'd3);
      chk("add_val_2", rs_val_2, 32'd4);
      tick();
      chk("add_alu_rob_id", alu_rob_id, 4'd2);

      // SUB waiting on tag 5, woken by LSB CDB
      set_dec(4'd2, 4'd3, 32'd0, 32'd1, 1'b1, 4'd5);
      tick(); clear_in();
      tick(); tick();
      cdb_lsb_ready = 1; cdb_lsb_rob_id = 4'd5; cdb_lsb_value = 32'd10;
      tick(); clear_in();
      tick();
      chk("sub_rs_ready", rs_ready, 1'b1);
      chk("sub_rs_op", rs_op, 4'd2);
      chk("sub_val_1", rs_val_1, 32'd10);
      chk("sub_val_2", rs_val_2, 32'd1);

      // Capture of a broadcast coincident with dispatch
      set_dec(4'd1, 4'd4, 32'd0, 32'd5, 1'b1, 4'd7);
      cdb_alu_ready = 1; cdb_alu_rob_id = 4'd7; cdb_alu_value = 32'h20;
      tick(); clear_in();
      tick();
      chk("cap_rs_ready", rs_ready, 1'b1);
      chk("cap_val_1", rs_val_1, 32'h20);

      // Fill all entries pending on tag 1, then drain
      for (int k = 0; k < N; k++) begin
         set_dec(4'(k), 4'(8 + k), 32'(k), 32'(100 + k), 1'b1, 4'd1);
         tick();
      end
      chk("fill_full", full, 1'b1);
      set_dec(4'd15, 4'd0, 32'd1, 32'd1, 1'b0, 4'd0);
      tick(); clear_in();
      cdb_alu_ready = 1; cdb_alu_rob_id = 4'd1; cdb_alu_value = 32'h55;
      tick(); clear_in();
      for (int k = 0; k < N; k++) begin
         tick();
         chk("drain_rs_ready", rs_ready, 1'b1);
         chk("drain_rs_op", rs_op, 4'(k));
         if (k == 0) chk("drain_full_drop", full, 1'b0);
      end
      tick();
      chk("drain_overflow_absent", rs_ready, 1'b0);

      // Slot reuse: younger op lands in a lower slot than an older pending op
      set_dec(4'd7, 4'd1, 32'd1, 32'd1, 1'b0, 4'd0);
      tick();
      set_dec(4'd5, 4'd2, 32'd0, 32'd2, 1'b1, 4'd6);
      tick();
      set_dec(4'd6, 4'd3, 32'd0, 32'd3, 1'b1, 4'd6);
      tick(); clear_in();
      cdb_lsb_ready = 1; cdb_lsb_rob_id = 4'd6; cdb_lsb_value = 32'h66;
      tick(); clear_in();
`ifdef RS_AGE_ORDER_EN
      first_op = 4'd5; second_op = 4'd6;
`else
      first_op = 4'd6; second_op = 4'd5;
`endif
      tick();
      chk("reuse_first_op", rs_op, first_op);
      tick();
      chk("reuse_second_op", rs_op, second_op);
      tick();

      // Flush with coincident dispatch and CDB match
      set_dec(4'd3, 4'd5, 32'd0, 32'd0, 1'b1, 4'd3);
      tick();
      set_dec(4'd3, 4'd6, 32'd0, 32'd0, 1'b1, 4'd3);
      tick();
      set_dec(4'd9, 4'd7, 32'd0, 32'd9, 1'b1, 4'd4);
      flush = 1;
      cdb_alu_ready = 1; cdb_alu_rob_id = 4'd3; cdb_alu_value = 32'h33;
      cdb_lsb_ready = 1; cdb_lsb_rob_id = 4'd4; cdb_lsb_value = 32'h44;
      tick(); clear_in();
      chk("flush_rs_ready", rs_ready, 1'b0);
      chk("flush_full", full, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("flush_no_issue", rs_ready, 1'b0);
      end

      // Asynchronous reset mid-run with 5 entries busy and an issue in flight
      for (int k = 0; k < 6; k++) begin
         set_dec(4'd3, 4'(k), 32'd0, 32'(k), 1'b1, 4'd9);
         tick();
      end
      clear_in();
      cdb_alu_ready = 1; cdb_alu_rob_id = 4'd9; cdb_alu_value = 32'h99;
      tick(); clear_in();
      tick();
      chk("pre_reset_rs_ready", rs_ready, 1'b1);
      rst = 1;
      #1;
      model_clear();
      chk("async_reset_full", full, 1'b0);
      chk("async_reset_rs_ready", rs_ready, 1'b0);
      tick();
      rst = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("post_reset_no_issue", rs_ready, 1'b0);
      end

      // Randomized traffic
      for (int k = 0; k < 500; k++) begin
         dec_valid      = ($urandom_range(0, 3) != 0);
         dec_op         = 4'($urandom);
         dec_rob_id     = 4'($urandom);
         dec_val_1      = $urandom;
         dec_val_2      = $urandom;
         dec_dep_1      = 1'($urandom_range(0, 1));
         dec_dep_2      = 1'($urandom_range(0, 1));
         dec_tag_1      = 4'($urandom_range(0, 7));
         dec_tag_2      = 4'($urandom_range(0, 7));
         cdb_alu_ready  = ($urandom_range(0, 2) == 0);
         cdb_alu_rob_id = 4'($urandom_range(0, 7));
         cdb_alu_value  = $urandom;
         cdb_lsb_ready  = ($urandom_range(0, 2) == 0);
         cdb_lsb_rob_id = 4'($urandom_range(0, 7));
         cdb_lsb_value  = $urandom;
         flush          = ($urandom_range(0, 59) == 0);
         tick();
      end
      clear_in();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
